// File: rtl/vector_cpu_pkg.sv
// Shared types and defaults for the vector CPU pipeline control blocks.
// Holds the hazard FSM state enum, the scalar operand encoding and the lane-select width helper.
package vector_cpu_pkg;

    localparam int R_DEF = 6;
    localparam int N_DEF = 8;

    localparam logic [1:0] VSI_SCALAR = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        VMEM = 1'b1
    } hazard_state_t;

    typedef logic [N_DEF-1:0] lane_data_t;

    function automatic int lane_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/vector_hazard_ctrl_if.sv
// E/D-stage hazard inputs and pipeline control outputs of the hazard sequencer.
// All signals are level-based: each output is valid in the same cycle as the E/D inputs that produce it.
interface vector_hazard_ctrl_if
    import vector_cpu_pkg::*;
#(
    parameter int LW = lane_w(R_DEF)
);
    logic          RegWriteE;
    logic          MemtoRegE;
    logic          MemWriteE;
    logic [1:0]    VSIFlagE;
    logic [3:0]    WA3E;
    logic [3:0]    RA1D;
    logic [3:0]    RA2D;
    logic          StallF;
    logic          StallD;
    logic          StallE;
    logic          FlushE;
    logic [LW-1:0] LaneSel;
    logic          MemLaneValid;
    logic          VMemDone;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, VSIFlagE, WA3E, RA1D, RA2D,
        input  StallF, StallD, StallE, FlushE, LaneSel, MemLaneValid, VMemDone
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, VSIFlagE, WA3E, RA1D, RA2D,
        output StallF, StallD, StallE, FlushE, LaneSel, MemLaneValid, VMemDone
    );

endinterface

// File: rtl/vmem_lane_counter.sv
// Lane counter for a vector memory op: load-1 on op start, increment per lane, clear on last lane.
// Updates on the falling clock edge, matching the pipeline registers.
module vmem_lane_counter
    import vector_cpu_pkg::*;
#(
    parameter int R = R_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load1_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [lane_w(R)-1:0] cnt_o,
    output logic                 last_o
);
    localparam int LW = lane_w(R);

    logic [LW-1:0] cnt_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load1_i) begin
            cnt_q <= LW'(1);
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LW'(R - 1));

endmodule

// File: rtl/vector_hazard_ctrl.sv
// Stall/flush sequencer beside the ID/EX register: walks vector memory ops lane by lane and bubbles load-use hazards.
// Optional HAZARD_PERF_EN adds saturating StallCycles/BubbleCount counters.
module vector_hazard_ctrl
    import vector_cpu_pkg::*;
#(
    parameter int R = R_DEF
) (
    input  logic          clk,
    input  logic          reset,
    vector_hazard_ctrl_if.slave hz,
    output hazard_state_t state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]   StallCycles,
    output logic [15:0]   BubbleCount
`endif
);
    localparam int LW = lane_w(R);

    hazard_state_t state_q, state_d;
    logic [LW-1:0] lane_cnt;
    logic          last_lane;
    logic          vmem, luhaz;
    logic          stall_fd, stall_e, flush_e, mlv, done;
    logic          load1, inc, clr;

    assign vmem  = (hz.MemtoRegE | hz.MemWriteE) & (hz.VSIFlagE != VSI_SCALAR);
    assign luhaz = hz.MemtoRegE & hz.RegWriteE & (hz.WA3E != 4'd0)
                 & ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));

    always_comb begin
        state_d  = state_q;
        stall_fd = 1'b0;
        stall_e  = 1'b0;
        flush_e  = 1'b0;
        mlv      = 1'b0;
        done     = 1'b0;
        load1    = 1'b0;
        inc      = 1'b0;
        clr      = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (vmem) begin
                        mlv = 1'b1;
                        if (R > 1) begin
                            stall_fd = 1'b1;
                            stall_e  = 1'b1;
                            load1    = 1'b1;
                            state_d  = VMEM;
                        end else begin
                            // Single-lane op: first lane is also the last one.
                            done     = 1'b1;
                            clr      = 1'b1;
                            flush_e  = luhaz;
                            stall_fd = luhaz;
                        end
                    end else if (luhaz) begin
                        stall_fd = 1'b1;
                        flush_e  = 1'b1;
                    end
                end
                VMEM: begin
                    mlv = 1'b1;
                    if (!last_lane) begin
                        stall_fd = 1'b1;
                        stall_e  = 1'b1;
                        inc      = 1'b1;
                    end else begin
                        // The op leaves E now, so a pending load-use hazard may bubble.
                        done     = 1'b1;
                        clr      = 1'b1;
                        state_d  = IDLE;
                        flush_e  = luhaz;
                        stall_fd = luhaz;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    vmem_lane_counter #(.R(R)) u_lane_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .load1_i (load1),
        .inc_i   (inc),
        .clr_i   (clr),
        .cnt_o   (lane_cnt),
        .last_o  (last_lane)
    );

    assign hz.StallF       = stall_fd;
    assign hz.StallD       = stall_fd;
    assign hz.StallE       = stall_e;
    assign hz.FlushE       = flush_e;
    assign hz.MemLaneValid = mlv;
    assign hz.VMemDone     = done;
    assign hz.LaneSel      = mlv ? lane_cnt : '0;
    assign state_o         = state_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles_q, bubble_count_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            bubble_count_q <= '0;
        end else begin
            if (stall_fd && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (flush_e && (bubble_count_q != 16'hFFFF)) begin
                bubble_count_q <= bubble_count_q + 16'd1;
            end
        end
    end

    assign StallCycles = stall_cycles_q;
    assign BubbleCount = bubble_count_q;
`endif

endmodule

// File: tb/tb_vector_hazard_ctrl.sv
// Bench for vector_hazard_ctrl (R=6): directed scenarios with literal expectations plus a per-cycle lane-walk model.
// Define HAZARD_PERF_EN to also check the stall/bubble counters and their saturation.
module tb_vector_hazard_ctrl;
    import vector_cpu_pkg::*;

    localparam int R  = 6;
    localparam int LW = lane_w(R);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    hazard_state_t dut_state;
`ifdef HAZARD_PERF_EN
    logic [15:0]   stall_cycles, bubble_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // model: number of lanes of the current vector op already issued (0 = none in flight)
    int op_lane = 0;
    int m_stalls = 0;
    int m_bubbles = 0;

    vector_hazard_ctrl_if #(.LW(LW)) hz ();

    vector_hazard_ctrl #(.R(R)) dut (
        .clk         (clk),
        .reset       (reset),
        .hz          (hz.slave),
        .state_o     (dut_state)
`ifdef HAZARD_PERF_EN
        ,
        .StallCycles (stall_cycles),
        .BubbleCount (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_outs(input logic sf, input logic sd, input logic se,
                                               input logic fl, input logic mlv, input logic dn,
                                               input logic [7:0] lane);
        return {18'd0, sf, sd, se, fl, mlv, dn, lane};
    endfunction

    function automatic logic [31:0] dut_outs();
        return pack_outs(hz.StallF, hz.StallD, hz.StallE, hz.FlushE, hz.MemLaneValid,
                         hz.VMemDone, 8'(hz.LaneSel));
    endfunction

    function automatic bit m_vmem();
        return (hz.MemtoRegE || hz.MemWriteE) && (hz.VSIFlagE != 2'b00);
    endfunction

    function automatic bit m_luhaz();
        return hz.MemtoRegE && hz.RegWriteE && (hz.WA3E != 0)
            && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
    endfunction

    // An op is in E if one is already walking or a vector mem op just arrived.
    function automatic bit m_active();
        return (op_lane > 0) || m_vmem();
    endfunction

    function automatic logic [31:0] model_outs();
        bit act, last, flush, stall_e;
        if (!reset) return 32'd0;
        act     = m_active();
        last    = act && (op_lane == R - 1);
        stall_e = act && !last;
        flush   = m_luhaz() && (!act || last);
        return pack_outs(stall_e || flush, stall_e || flush, stall_e, flush, act, last,
                         act ? 8'(op_lane) : 8'd0);
    endfunction

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            op_lane   = 0;
            m_stalls  = 0;
            m_bubbles = 0;
        end else begin
            logic [31:0] e;
            e = model_outs();
            if (e[13] && m_stalls < 65535) m_stalls++;
            if (e[10] && m_bubbles < 65535) m_bubbles++;
            if (m_active()) op_lane = (op_lane == R - 1) ? 0 : op_lane + 1;
        end
    end

    initial begin
        @(negedge clk);
        forever begin
            @(posedge clk);
            #3;
            check("model_outs", dut_outs(), model_outs());
            check("model_state", {31'd0, dut_state == VMEM}, {31'd0, reset && (op_lane > 0)});
`ifdef HAZARD_PERF_EN
            check("model_stall_cycles", {16'd0, stall_cycles}, 32'(m_stalls));
            check("model_bubble_count", {16'd0, bubble_count}, 32'(m_bubbles));
`endif
        end
    end

    task automatic drive(input bit rst, input bit rw, input bit m2r, input bit mw,
                         input logic [1:0] vsi, input logic [3:0] wa3,
                         input logic [3:0] ra1, input logic [3:0] ra2);
        @(posedge clk);
        #1;
        reset        = rst;
        hz.RegWriteE = rw;
        hz.MemtoRegE = m2r;
        hz.MemWriteE = mw;
        hz.VSIFlagE  = vsi;
        hz.WA3E      = wa3;
        hz.RA1D      = ra1;
        hz.RA2D      = ra2;
    endtask

    task automatic expect_outs(input string name, input bit sf, input bit sd, input bit se,
                               input bit fl, input bit mlv, input bit dn, input int lane);
        #3;
        check(name, dut_outs(), pack_outs(sf, sd, se, fl, mlv, dn, 8'(lane)));
    endtask

    task automatic nop_cycle(input string name);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
        expect_outs(name, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        hz.RegWriteE = 1'b0;
        hz.MemtoRegE = 1'b0;
        hz.MemWriteE = 1'b0;
        hz.VSIFlagE  = 2'b00;
        hz.WA3E      = 4'd0;
        hz.RA1D      = 4'd0;
        hz.RA2D      = 4'd0;

        // reset held with a vector load waiting in E
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 2'b01, 4'd1, 4'd2, 4'd3);
            expect_outs("reset_hold", 0, 0, 0, 0, 0, 0, 0);
        end
        // release: lanes 0..5, stalls on 0-4, done on 5
        for (int i = 0; i < R; i++) begin
            drive(1, 1, 1, 0, 2'b01, 4'd1, 4'd2, 4'd3);
            expect_outs($sformatf("vload_lane%0d", i), i < R - 1, i < R - 1, i < R - 1,
                        0, 1, i == R - 1, i);
        end
        nop_cycle("idle_after_vload");

        // vector store, other non-scalar encoding
        for (int i = 0; i < R; i++) begin
            drive(1, 0, 0, 1, 2'b10, 4'd4, 4'd4, 4'd4);
            expect_outs($sformatf("vstore_lane%0d", i), i < R - 1, i < R - 1, i < R - 1,
                        0, 1, i == R - 1, i);
        end
        nop_cycle("idle_after_vstore");

        // scalar load-use hazard: one bubble, then nothing
        drive(1, 1, 1, 0, 2'b00, 4'd3, 4'd0, 4'd3);
        expect_outs("scalar_luhaz", 1, 1, 0, 1, 0, 0, 0);
        nop_cycle("bubble_in_e");

        // vector load with hazard: flush only on the last lane
        for (int i = 0; i < R; i++) begin
            drive(1, 1, 1, 0, 2'b01, 4'd5, 4'd5, 4'd0);
            if (i < R - 1)
                expect_outs($sformatf("vload_haz_lane%0d", i), 1, 1, 1, 0, 1, 0, i);
            else
                expect_outs("vload_haz_last", 1, 1, 0, 1, 1, 1, i);
        end
        nop_cycle("idle_after_vload_haz");

        // r0 never hazards; scalar store never stalls
        drive(1, 1, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0);
        expect_outs("wa3_zero", 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 2'b00, 4'd7, 4'd7, 4'd7);
        expect_outs("scalar_store", 0, 0, 0, 0, 0, 0, 0);

        // reset on lane 3 aborts, release restarts at lane 0
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 2'b01, 4'd9, 4'd1, 4'd2);
            expect_outs($sformatf("abort_lane%0d", i), 1, 1, 1, 0, 1, 0, i);
        end
        drive(0, 1, 1, 0, 2'b01, 4'd9, 4'd1, 4'd2);
        expect_outs("abort_reset", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < R; i++) begin
            drive(1, 1, 1, 0, 2'b01, 4'd9, 4'd1, 4'd2);
            expect_outs($sformatf("restart_lane%0d", i), i < R - 1, i < R - 1, i < R - 1,
                        0, 1, i == R - 1, i);
        end
        nop_cycle("idle_after_restart");

`ifdef HAZARD_PERF_EN
        // counters cleared by the abort reset: 5 stall lanes since, no bubbles
        check("perf_after_restart_stalls", {16'd0, stall_cycles}, 32'd5);
        check("perf_after_restart_bubbles", {16'd0, bubble_count}, 32'd0);
        drive(1, 1, 1, 0, 2'b00, 4'd3, 4'd3, 4'd0);
        expect_outs("perf_luhaz", 1, 1, 0, 1, 0, 0, 0);
        nop_cycle("perf_idle");
        check("perf_luhaz_stalls", {16'd0, stall_cycles}, 32'd6);
        check("perf_luhaz_bubbles", {16'd0, bubble_count}, 32'd1);
        // back-to-back hazards until both counters pin at the top
        for (int i = 0; i < 65540; i++) begin
            drive(1, 1, 1, 0, 2'b00, 4'd3, 4'd3, 4'd0);
        end
        nop_cycle("perf_sat_idle");
        check("perf_sat_stalls", {16'd0, stall_cycles}, 32'h0000FFFF);
        check("perf_sat_bubbles", {16'd0, bubble_count}, 32'h0000FFFF);
`endif

        @(posedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
